// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction
// memory (slave).
//
// Handshake: the master raises imem_req with imem_addr and holds both stable
// until the slave answers with a single-cycle imem_valid strobe carrying
// imem_rdata. There is no back-pressure on the response. A strobe that
// arrives while imem_req is low is not a response and is dropped.
//
// Signals:
//   imem_req    master -> slave  fetch request
//   imem_addr   master -> slave  fetch address (PC_WIDTH bits)
//   imem_rdata  slave  -> master instruction word (16 bits)
//   imem_valid  slave  -> master response strobe
interface fetch_unit_if #(
  parameter int PC_WIDTH = 16
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [15:0]         imem_rdata;
  logic                imem_valid;

  modport master (output imem_req, output imem_addr,
                  input  imem_rdata, input imem_valid);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_rdata, output imem_valid);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end. Fetches one 16-bit instruction at a time,
// holds it for the decoder until the decoder accepts it (stall low), then
// picks the next PC from the decoder's branch/branch-register/halt
// indications, the condition code and the {Z,V,N} flags. Owns the halted
// state of the core, which is left only through reset.
//
// Optional feature: define FETCH_PERF_CNT_EN to add the saturating
// retired_cnt / taken_cnt performance counters.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   imem                instruction-memory bus (master side)
//   instr, instr_valid  instruction presented to the decoder
//   pc_cur, pc_plus2    PC of instr and PC of instr plus 2
//   stall               decoder cannot accept instr this cycle
//   branch, branch_reg  decoder: B / BR instruction
//   halt                decoder: HLT instruction
//   ccc, flags          condition field and {Z,V,N}
//   imm9, reg_target    B offset (words, signed) and BR target
//   taken               one-cycle pulse when a redirect was applied
//   halted              core halted
//   retired_cnt         (optional) instructions retired
//   taken_cnt           (optional) redirects taken
//   dbg_state           current FSM state encoding
module fetch_unit #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  fetch_unit_if.master        imem,
  output logic [15:0]         instr,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] pc_cur,
  output logic [PC_WIDTH-1:0] pc_plus2,
  input  logic                stall,
  input  logic                branch,
  input  logic                branch_reg,
  input  logic                halt,
  input  logic [2:0]          ccc,
  input  logic [2:0]          flags,
  input  logic [8:0]          imm9,
  input  logic [PC_WIDTH-1:0] reg_target,
  output logic                taken,
  output logic                halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]         retired_cnt,
  output logic [15:0]         taken_cnt,
`endif
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [PC_WIDTH-1:0] pc, pc_d;
  logic [PC_WIDTH-1:0] br_off, br_target;
  logic                taken_d;
  logic                cond_true;
  logic                flag_z, flag_v, flag_n;
  logic                accept;

  assign flag_z = flags[2];
  assign flag_v = flags[1];
  assign flag_n = flags[0];

  always_comb begin
    cond_true = 1'b0;
    case (ccc)
      3'b000: cond_true = !flag_z;
      3'b001: cond_true = flag_z;
      3'b010: cond_true = !flag_z && !flag_n;
      3'b011: cond_true = flag_n;
      3'b100: cond_true = flag_z || (!flag_z && !flag_n);
      3'b101: cond_true = flag_n || flag_z;
      3'b110: cond_true = flag_v;
      3'b111: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // All PC arithmetic is PC_WIDTH wide, so it wraps naturally.
  assign pc_plus2  = pc_cur + PC_WIDTH'(2);
  assign br_off    = {{(PC_WIDTH-9){imm9[8]}}, imm9} << 1;
  assign br_target = pc_plus2 + br_off;

  assign accept = (state == S_FETCH) && imem.imem_valid;

  // Next-state and next-PC. In HOLD, halt outranks BR, which outranks B.
  always_comb begin
    state_d = state;
    pc_d    = pc;
    taken_d = 1'b0;
    case (state)
      S_FETCH: begin
        if (imem.imem_valid) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!stall) begin
          if (halt) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_FETCH;
            if (branch_reg && cond_true) begin
              pc_d    = {reg_target[PC_WIDTH-1:1], 1'b0};
              taken_d = 1'b1;
            end else if (branch && cond_true) begin
              pc_d    = br_target;
              taken_d = 1'b1;
            end else begin
              pc_d = pc_plus2;
            end
          end
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      pc_cur <= RESET_PC;
      instr  <= 16'h0000;
      taken  <= 1'b0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      taken <= taken_d;
      if (accept) begin
        instr  <= imem.imem_rdata;
        pc_cur <= pc;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= 16'h0000;
      taken_cnt   <= 16'h0000;
    end else begin
      if (state == S_HOLD && !stall && retired_cnt != 16'hFFFF)
        retired_cnt <= retired_cnt + 16'd1;
      if (taken_d && taken_cnt != 16'hFFFF)
        taken_cnt <= taken_cnt + 16'd1;
    end
  end
`endif

  // The request is masked while rst is high so nothing is issued in the
  // reset cycle, whatever state the FSM was in.
  assign imem.imem_req  = (state == S_FETCH) && !rst;
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == S_HOLD);
  assign halted         = (state == S_HALTED);
  assign dbg_state      = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed steps plus a randomized instruction
// stream, checked against a PC model computed from the branch rules.
module tb_fetch_unit;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   instr;
  logic          instr_valid;
  logic [PW-1:0] pc_cur, pc_plus2;
  logic          stall = 1'b0;
  logic          branch = 1'b0;
  logic          branch_reg = 1'b0;
  logic          halt = 1'b0;
  logic [2:0]    ccc = 3'b000;
  logic [2:0]    flags = 3'b000;
  logic [8:0]    imm9 = 9'h000;
  logic [PW-1:0] reg_target = '0;
  logic          taken, halted;
  logic [1:0]    dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]   retired_cnt, taken_cnt;
`endif

  fetch_unit_if #(.PC_WIDTH(PW)) imem_bus ();

  fetch_unit #(.PC_WIDTH(PW), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (imem_bus),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc_cur     (pc_cur),
    .pc_plus2   (pc_plus2),
    .stall      (stall),
    .branch     (branch),
    .branch_reg (branch_reg),
    .halt       (halt),
    .ccc        (ccc),
    .flags      (flags),
    .imm9       (imm9),
    .reg_target (reg_target),
    .taken      (taken),
    .halted     (halted),
`ifdef FETCH_PERF_CNT_EN
    .retired_cnt(retired_cnt),
    .taken_cnt  (taken_cnt),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;
  logic [15:0] m_pc;
  logic [15:0] m_instr;
  int          m_retired;
  int          m_taken;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Branch condition from the condition table, with f = {Z,V,N}.
  function automatic bit cond_model(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0; branch = 1'b0; branch_reg = 1'b0; halt = 1'b0;
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 16'h0000;
    tick();
    check("rst_req", imem_bus.imem_req, 1'b0);
    check("rst_ivalid", instr_valid, 1'b0);
    check("rst_instr", instr, 16'h0000);
    check("rst_taken", taken, 1'b0);
    check("rst_halted", halted, 1'b0);
    rst = 1'b0;
    tick();
    check("post_rst_req", imem_bus.imem_req, 1'b1);
    check("post_rst_addr", imem_bus.imem_addr, 16'h0000);
    m_pc = 16'h0000;
    m_retired = 0;
    m_taken = 0;
`ifdef FETCH_PERF_CNT_EN
    check("rst_retired_cnt", retired_cnt, 16'd0);
    check("rst_taken_cnt", taken_cnt, 16'd0);
`endif
  endtask

  // Called in a FETCH cycle; waits, then returns data one cycle later.
  task automatic do_fetch(input logic [15:0] data, input int waits);
    logic [15:0] p2;
    for (int i = 0; i < waits; i++) begin
      stall = 1'($urandom_range(0, 1));
      tick();
      check("fetch_wait_req", imem_bus.imem_req, 1'b1);
      check("fetch_wait_addr", imem_bus.imem_addr, m_pc);
      check("fetch_wait_taken", taken, 1'b0);
      check("fetch_wait_ivalid", instr_valid, 1'b0);
    end
    check("fetch_req", imem_bus.imem_req, 1'b1);
    check("fetch_addr", imem_bus.imem_addr, m_pc);
    imem_bus.imem_rdata = data;
    imem_bus.imem_valid = 1'b1;
    tick();
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 16'($urandom);
    stall = 1'b0;
    p2 = m_pc + 16'd2;
    check("hold_ivalid", instr_valid, 1'b1);
    check("hold_instr", instr, data);
    check("hold_pc_cur", pc_cur, m_pc);
    check("hold_pc_plus2", pc_plus2, p2);
    check("hold_req", imem_bus.imem_req, 1'b0);
    m_instr = data;
  endtask

  // Stalls in HOLD for n cycles with spurious memory strobes.
  task automatic do_hold(input int n);
    for (int i = 0; i < n; i++) begin
      stall = 1'b1;
      imem_bus.imem_valid = 1'($urandom_range(0, 1));
      imem_bus.imem_rdata = 16'($urandom);
      branch = 1'($urandom_range(0, 1));
      halt = 1'($urandom_range(0, 1));
      tick();
      check("stall_instr", instr, m_instr);
      check("stall_pc_cur", pc_cur, m_pc);
      check("stall_ivalid", instr_valid, 1'b1);
      check("stall_req", imem_bus.imem_req, 1'b0);
      check("stall_taken", taken, 1'b0);
    end
    stall = 1'b0;
    branch = 1'b0;
    halt = 1'b0;
    imem_bus.imem_valid = 1'b0;
  endtask

  // Releases the instruction in HOLD with the given decode indications.
  task automatic do_resolve(input logic br, input logic brr, input logic hlt,
                            input logic [2:0] c, input logic [2:0] f,
                            input logic [8:0] imm, input logic [15:0] tgt);
    int s;
    int nxt;
    bit tk;
    bit ct;
    ct = cond_model(c, f);
    s = imm[8] ? int'(imm) - 512 : int'(imm);
    tk = 1'b0;
    nxt = int'(m_pc);
    if (hlt) begin
      nxt = int'(m_pc);
    end else if (brr && ct) begin
      nxt = int'(tgt) & 32'h0000_FFFE;
      tk = 1'b1;
    end else if (br && ct) begin
      nxt = (int'(m_pc) + 2 + 2 * s) & 32'h0000_FFFF;
      tk = 1'b1;
    end else begin
      nxt = (int'(m_pc) + 2) & 32'h0000_FFFF;
    end
    stall = 1'b0;
    branch = br; branch_reg = brr; halt = hlt;
    ccc = c; flags = f; imm9 = imm; reg_target = tgt;
    tick();
    branch = 1'b0; branch_reg = 1'b0; halt = 1'b0;
    ccc = 3'($urandom); flags = 3'($urandom);
    check("res_taken", taken, tk);
    check("res_halted", halted, hlt);
    check("res_ivalid", instr_valid, 1'b0);
    check("res_req", imem_bus.imem_req, !hlt);
    if (!hlt) check("res_next_addr", imem_bus.imem_addr, nxt[15:0]);
    m_pc = nxt[15:0];
    m_retired++;
    if (tk) m_taken++;
`ifdef FETCH_PERF_CNT_EN
    check("retired_cnt", retired_cnt, m_retired[15:0]);
    check("taken_cnt", taken_cnt, m_taken[15:0]);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = 16'h0000;

    // Reset, then run two sequential instructions.
    do_reset();
    do_fetch(16'h0123, 0);
    do_resolve(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 9'h000, 16'h0000);
    check("seq_addr_0002", imem_bus.imem_addr, 16'h0002);
    do_fetch(16'h1456, 2);

    // BR with odd target.
    do_resolve(1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 9'h000, 16'h3457);
    check("br_odd_addr", imem_bus.imem_addr, 16'h3456);
    check("br_odd_taken", taken, 1'b1);

    // Get to 0x0010, then taken backward B.
    do_fetch(16'hD000, 1);
    do_resolve(1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 9'h000, 16'h0010);
    do_fetch(16'hC3FC, 1);
    do_resolve(1'b1, 1'b0, 1'b0, 3'b001, 3'b100, 9'h1FC, 16'h0000);
    check("b_back_addr", imem_bus.imem_addr, 16'h000A);
    check("b_back_taken", taken, 1'b1);

    // Same B at 0x0010 with Z=0: not taken.
    do_fetch(16'hD000, 0);
    do_resolve(1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 9'h000, 16'h0011);
    do_fetch(16'hC3FC, 0);
    do_resolve(1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 9'h1FC, 16'h0000);
    check("b_nt_addr", imem_bus.imem_addr, 16'h0012);
    check("b_nt_taken", taken, 1'b0);

    // Stall hold for 5 cycles with spurious strobes.
    do_fetch(16'h7777, 0);
    do_hold(5);
    do_resolve(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 9'h000, 16'h0000);
    check("stall_release_addr", imem_bus.imem_addr, 16'h0014);

    // Random stream.
    for (int k = 0; k < 40; k++) begin
      do_fetch(16'($urandom), $urandom_range(0, 3));
      do_hold($urandom_range(0, 2));
      do_resolve(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                 3'($urandom), 3'($urandom), 9'($urandom), 16'($urandom));
    end

    // Halt, stay halted for 20 cycles, then reset.
    do_fetch(16'hF000, 1);
    do_resolve(1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 9'h000, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      imem_bus.imem_valid = 1'($urandom_range(0, 1));
      stall = 1'($urandom_range(0, 1));
      tick();
      check("halted_stay", halted, 1'b1);
      check("halted_req", imem_bus.imem_req, 1'b0);
      check("halted_ivalid", instr_valid, 1'b0);
    end
    imem_bus.imem_valid = 1'b0;
    stall = 1'b0;
    do_reset();

    // Reset asserted mid-FETCH together with a memory strobe.
    rst = 1'b1;
    imem_bus.imem_valid = 1'b1;
    imem_bus.imem_rdata = 16'hBEEF;
    tick();
    check("rst_fetch_ivalid", instr_valid, 1'b0);
    check("rst_fetch_req", imem_bus.imem_req, 1'b0);
    rst = 1'b0;
    imem_bus.imem_valid = 1'b0;
    tick();
    check("rst_fetch_ivalid2", instr_valid, 1'b0);
    check("rst_fetch_instr", instr, 16'h0000);
    check("rst_fetch_addr", imem_bus.imem_addr, 16'h0000);
    check("rst_fetch_req2", imem_bus.imem_req, 1'b1);

    // Wrap from 0xFFFE; three retired instructions, one taken.
    do_reset();
    do_fetch(16'hD000, 0);
    do_resolve(1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 9'h000, 16'hFFFE);
    do_fetch(16'h1111, 1);
    do_resolve(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 9'h000, 16'h0000);
    check("wrap_addr", imem_bus.imem_addr, 16'h0000);
    do_fetch(16'h2222, 0);
    do_resolve(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 9'h000, 16'h0000);
    check("wrap_seq_addr", imem_bus.imem_addr, 16'h0002);
`ifdef FETCH_PERF_CNT_EN
    check("final_retired_cnt", retired_cnt, 16'd3);
    check("final_taken_cnt", taken_cnt, 16'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end for the WISC-S25 core. It drives the program counter, requests instruction words from instruction memory, and presents one instruction at a time to the decode/control logic.
- It consumes the decoder's branch, branch-register and halt indications, together with the condition code and flags, to pick the next PC.
- It owns the halted state of the core.

Parameters:
- PC_WIDTH, 16, width of the PC and instruction-memory address.
- RESET_PC, 16'h0000, PC loaded on reset.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; held high until imem_valid.
- imem_addr  output  PC_WIDTH  fetch address; equals the current PC while imem_req is high.
- imem_rdata  input  16  instruction word; sampled when imem_valid is high.
- imem_valid  input  1  instruction-memory response strobe.
- instr  output  16  registered instruction presented to the decoder.
- instr_valid  output  1  instr holds a live instruction.
- pc_cur  output  PC_WIDTH  PC of instr.
- pc_plus2  output  PC_WIDTH  pc_cur+2; used for PCS write-back and the B offset base.
- stall  input  1  downstream cannot accept instr this cycle.
- branch  input  1  decoder: B instruction (opcode 1100).
- branch_reg  input  1  decoder: BR instruction (opcode 1101).
- halt  input  1  decoder: HLT instruction (opcode 1111).
- ccc  input  3  condition field instr[11:9].
- flags  input  3  {Z,V,N} from the flag register.
- imm9  input  9  signed branch offset instr[8:0].
- reg_target  input  PC_WIDTH  rs data for BR.
- taken  output  1  one-cycle pulse: branch redirect applied.
- halted  output  1  core halted.

Behaviour:
- Reset (rst=1 at the clock edge; dominates all other inputs):
  - PC=RESET_PC, state=FETCH.
  - instr=16'h0000, instr_valid=0, imem_req=0 in the reset cycle.
  - taken=0, halted=0.
- Reset mid-operation discards any outstanding fetch. A late imem_valid after reset is ignored unless the FSM has re-entered FETCH and raised imem_req.
- States:
  - FETCH:
    - imem_req=1, imem_addr=PC.
    - On imem_valid: instr<=imem_rdata, pc_cur<=PC, instr_valid<=1, go to HOLD.
    - Latency: imem_valid in cycle N gives instr_valid in cycle N+1.
    - stall has no effect in FETCH.
  - HOLD:
    - instr_valid=1, imem_req=0; imem_valid is ignored.
    - While stall=1: hold every output unchanged.
    - When stall=0, resolve the next PC and go to FETCH (instr_valid<=0), except as follows:
      - halt=1: go to HALTED.
      - branch=1 and the condition is true: PC<=pc_plus2 + (sext(imm9)<<1), taken pulses for one cycle.
      - branch_reg=1 and the condition is true: PC<=reg_target, taken pulses for one cycle.
      - Otherwise: PC<=pc_plus2.
    - Priority: halt > branch_reg > branch > sequential.
  - HALTED:
    - halted=1, imem_req=0, instr_valid=0.
    - Exit only via rst.
- Condition (Z,V,N):
  - 000 NE: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 & N=0.
  - 011 LT: N=1.
  - 100 GE: Z=1 | (Z=0 & N=0).
  - 101 LE: N=1 | Z=1.
  - 110 OV: V=1.
  - 111: always true.
- Arithmetic:
  - All PC math is modulo 2^PC_WIDTH; 16'hFFFE+2 wraps to 16'h0000.
  - imm9 is sign-extended to PC_WIDTH, then shifted left by 1.
  - Bit 0 of reg_target is forced to 0.
- PCS needs nothing special: the datapath writes pc_plus2 back.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - retired_cnt[15:0]: counts HOLD exits with stall=0, including HLT.
  - taken_cnt[15:0]: counts taken pulses.
- Both counters reset to 0 on rst and saturate at 16'hFFFF.
- When undefined, the ports and registers are absent and all other behaviour is identical.

Test Plan:
- Reset then run: memory returns 16'h0123 at 0x0000 and 16'h1456 at 0x0002, stall=0 -> instr_valid at N+1 with instr=0x0123 and pc_cur=0x0000; next imem_addr=0x0002.
- Branch taken backward: pc_cur=0x0010, branch=1, ccc=001, Z=1, imm9=9'h1FC (-4) -> taken=1, next imem_addr=0x000A. Same case with Z=0 -> next imem_addr=0x0012, taken=0.
- BR with odd target: branch_reg=1, ccc=111, reg_target=0x3457 -> next imem_addr=0x3456, taken=1.
- Stall hold: instr_valid=1, stall=1 for 5 cycles with a spurious imem_valid -> instr and pc_cur unchanged, imem_req=0; on release the PC advances by exactly one instruction.
- Halt then reset: halt=1 with stall=0 -> halted=1 next cycle, imem_req stays 0 for 20 cycles; rst=1 -> halted=0, PC=RESET_PC. Reset asserted mid-FETCH with imem_valid in the same cycle -> instr_valid stays 0.
- Wrap and counters: PC=0xFFFE, sequential instruction -> next imem_addr=0x0000. With FETCH_PERF_CNT_EN defined, 3 retired instructions including 1 taken branch -> retired_cnt=3, taken_cnt=1.
